// File: rtl/ikaopm_dac_rx.sv
// ikaopm_dac_rx: YM3012-style DAC receiver. Deserialises the OPM SO stream
// framed by SH1/SH2 and converts each 13-bit floating-point word into a
// signed 16-bit PCM sample, with optional frame-length/overlap checking.
module ikaopm_dac_rx #(
    parameter bit LATCH_TOGETHER = 1'b0,
    parameter bit CHECK_FRAME    = 1'b1
) (
    input  logic        i_EMUCLK,
    input  logic        i_IC_n,
    input  logic        i_phi1_PCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    input  logic        i_ERR_CLR,
    output logic [15:0] o_EMU_L,
    output logic [15:0] o_EMU_R,
    output logic        o_L_VALID,
    output logic        o_R_VALID,
    output logic        o_FRAME_ERR
);

    logic        en;
    logic [15:0] sr;
    logic [15:0] sr_next;
    logic [15:0] shadow;
    logic [15:0] dec;
    logic [15:0] s16;
    logic [9:0]  mant;
    logic [2:0]  expo;
    logic        sh1_d;
    logic        sh2_d;
    logic        sh1_fall;
    logic        sh2_fall;
    logic [5:0]  frame_cnt;
    logic        armed;
    logic        frame_err;
    logic        err_set;

    assign en       = ~i_phi1_PCEN_n;
    assign sr_next  = {i_SO, sr[15:1]};
    assign sh1_fall = en & sh1_d & ~i_SH1;
    assign sh2_fall = en & sh2_d & ~i_SH2;

    // Floating-point decode of the word including the bit arriving this en
    always_comb begin
        mant = sr_next[12:3];
        expo = sr_next[15:13];
        s16  = {{7{~mant[9]}}, mant[8:0]};
        dec  = '0;
        if (expo != 3'd0) begin
            dec = s16 << (expo - 3'd1);
        end
    end

    // Framing fault: wrong SH2-to-SH2 period once armed, or SH1/SH2 overlap
    always_comb begin
        err_set = (sh2_fall & armed & (frame_cnt != 6'd31)) | (i_SH1 & i_SH2);
    end

    // Shift register, strobe history, sample latches and valid pulses
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sr        <= '0;
            sh1_d     <= 1'b0;
            sh2_d     <= 1'b0;
            shadow    <= '0;
            o_EMU_L   <= '0;
            o_EMU_R   <= '0;
            o_L_VALID <= 1'b0;
            o_R_VALID <= 1'b0;
        end else begin
            o_L_VALID <= 1'b0;
            o_R_VALID <= 1'b0;
            if (en) begin
                sr    <= sr_next;
                sh1_d <= i_SH1;
                sh2_d <= i_SH2;
                if (sh1_fall) begin
                    if (LATCH_TOGETHER) begin
                        shadow <= dec;
                    end else begin
                        o_EMU_L   <= dec;
                        o_L_VALID <= 1'b1;
                    end
                end
                if (sh2_fall) begin
                    o_EMU_R   <= dec;
                    o_R_VALID <= 1'b1;
                    if (LATCH_TOGETHER) begin
                        // a same-en SH1 fall has not reached the shadow yet
                        o_EMU_L   <= sh1_fall ? dec : shadow;
                        o_L_VALID <= 1'b1;
                    end
                end
            end
        end
    end

    // Frame period counter, arming flag and sticky error
    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            frame_cnt <= '0;
            armed     <= 1'b0;
            frame_err <= 1'b0;
        end else if (en && CHECK_FRAME) begin
            if (sh2_fall) begin
                frame_cnt <= '0;
                armed     <= 1'b1;
            end else if (frame_cnt != 6'd63) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (i_ERR_CLR) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign o_FRAME_ERR = CHECK_FRAME & frame_err;

endmodule

// File: tb/tb_ikaopm_dac_rx.sv
// Self-checking bench for ikaopm_dac_rx: one instance per LATCH_TOGETHER
// setting driven by the same stream, compared against a word-level model.
module tb_ikaopm_dac_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcen_n = 1'b1;
    logic        so = 1'b0, sh1 = 1'b0, sh2 = 1'b0, clr = 1'b0;
    logic [15:0] l0, r0, l1, r1;
    logic        lv0, rv0, lv1, rv1, err0, err1;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ikaopm_dac_rx #(.LATCH_TOGETHER(1'b0), .CHECK_FRAME(1'b1)) dut0 (
        .i_EMUCLK(clk), .i_IC_n(rst_n), .i_phi1_PCEN_n(pcen_n), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(clr),
        .o_EMU_L(l0), .o_EMU_R(r0), .o_L_VALID(lv0), .o_R_VALID(rv0),
        .o_FRAME_ERR(err0));

    ikaopm_dac_rx #(.LATCH_TOGETHER(1'b1), .CHECK_FRAME(1'b1)) dut1 (
        .i_EMUCLK(clk), .i_IC_n(rst_n), .i_phi1_PCEN_n(pcen_n), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(clr),
        .o_EMU_L(l1), .o_EMU_R(r1), .o_L_VALID(lv1), .o_R_VALID(rv1),
        .o_FRAME_ERR(err1));

    // ---------------- reference model (word level) ----------------
    bit          q[$];
    bit          m_sh1, m_sh2, m_armed, stall;
    int          m_cnt;
    logic [15:0] e_l0, e_l1, e_r, m_shadow;
    logic        e_lv0, e_lv1, e_rv, e_err;

    function automatic logic [15:0] model_word();
        logic [15:0] w = '0;
        int off = 16 - q.size();
        foreach (q[i]) w[i + off] = q[i];
        return w;
    endfunction

    function automatic logic [15:0] decode(input logic [15:0] w);
        int m = int'(w[12:3]);
        int e = int'(w[15:13]);
        if (e == 0) return 16'h0000;
        return 16'((m - 512) * (1 << (e - 1)));
    endfunction

    task automatic model_reset();
        q.delete();
        m_sh1 = 0; m_sh2 = 0; m_armed = 0; m_cnt = 0;
        e_l0 = '0; e_l1 = '0; e_r = '0; m_shadow = '0;
        e_lv0 = 0; e_lv1 = 0; e_rv = 0; e_err = 0;
    endtask

    task automatic model_en(input bit b, input bit s1, input bit s2, input bit c);
        bit f1 = m_sh1 & ~s1;
        bit f2 = m_sh2 & ~s2;
        bit set;
        logic [15:0] d;
        m_sh1 = s1; m_sh2 = s2;
        q.push_back(b);
        if (q.size() > 16) void'(q.pop_front());
        d = decode(model_word());
        e_lv0 = f1; e_lv1 = f2; e_rv = f2;
        if (f1) begin e_l0 = d; m_shadow = d; end
        if (f2) begin e_r = d; e_l1 = m_shadow; end
        m_cnt++;
        set = (f2 && m_armed && m_cnt != 32) || (s1 && s2);
        if (f2) begin m_cnt = 0; m_armed = 1; end
        if (set) e_err = 1; else if (c) e_err = 0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs();
        chk("L_lt0", l0, e_l0);   chk("L_lt1", l1, e_l1);
        chk("R_lt0", r0, e_r);    chk("R_lt1", r1, e_r);
        chk("LV_lt0", 16'(lv0), 16'(e_lv0)); chk("LV_lt1", 16'(lv1), 16'(e_lv1));
        chk("RV_lt0", 16'(rv0), 16'(e_rv));  chk("RV_lt1", 16'(rv1), 16'(e_rv));
        chk("ERR_lt0", 16'(err0), 16'(e_err)); chk("ERR_lt1", 16'(err1), 16'(e_err));
    endtask

    task automatic chk_valid_low();
        chk("LV0_low", 16'(lv0), 16'h0); chk("LV1_low", 16'(lv1), 16'h0);
        chk("RV0_low", 16'(rv0), 16'h0); chk("RV1_low", 16'(rv1), 16'h0);
    endtask

    // One enable: drive, let one en edge pass, check, then one idle edge
    task automatic step(input bit b, input bit s1, input bit s2, input bit c);
        @(negedge clk);
        chk_valid_low();
        if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
        so = b; sh1 = s1; sh2 = s2; clr = c; pcen_n = 1'b0;
        model_en(b, s1, s2, c);
        e_lv0 = e_lv0; // keep expectations for this en
        @(negedge clk);
        pcen_n = 1'b1;
        chk_outputs();
        e_lv0 = 0; e_lv1 = 0; e_rv = 0;
    endtask

    // 32-en frame: L word at k=0..15 (SH1 falls at 15), R word at 16..31
    task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw,
                              input int ks, input int ke,
                              input bit ltchk, input logic [15:0] el);
        for (int k = ks; k <= ke; k++) begin
            step(k < 16 ? lw[k] : rw[k - 16], (k >= 8 && k <= 14),
                 (k >= 24 && k <= 30), 1'b0);
            if (ltchk && k == 15) begin
                chk("lt1_L_held", l1, 16'h0000);
                chk("lt0_L_new", l0, el);
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; pcen_n = 1'b1;
        #1;
        model_reset();
        chk_outputs();
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [9:0]  lm; logic [2:0] le;
        logic [9:0]  rm; logic [2:0] re;
        logic [15:0] el; logic [15:0] er;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [15:0] lw, rw;
        tbl[0] = '{10'h3FF, 3'd7, 10'h000, 3'd7, 16'h7FC0, 16'h8000};
        tbl[1] = '{10'h3FF, 3'd7, 10'h201, 3'd3, 16'h7FC0, 16'h0004};
        tbl[2] = '{10'h200, 3'd4, 10'h1FF, 3'd1, 16'h0000, 16'hFFFF};
        tbl[3] = '{10'h000, 3'd1, 10'h2AB, 3'd0, 16'hFE00, 16'h0000};
        tbl[4] = '{10'h000, 3'd7, 10'h3FF, 3'd7, 16'h8000, 16'h7FC0};
        stall = 0;
        model_reset();

        // reset, then idle without enables
        do_reset(4);
        repeat (4) @(negedge clk);
        chk_outputs();
        chk_valid_low();

        // table of decode vectors, one frame each
        foreach (tbl[i]) begin
            lw = {tbl[i].le, tbl[i].lm, 3'($urandom)};
            rw = {tbl[i].re, tbl[i].rm, 3'($urandom)};
            send_frame(lw, rw, 0, 31, (i == 0), tbl[i].el);
            chk("tbl_L_lt0", l0, tbl[i].el);
            chk("tbl_L_lt1", l1, tbl[i].el);
            chk("tbl_R", r0, tbl[i].er);
            chk("tbl_R_lt1", r1, tbl[i].er);
        end
        chk("err_after_nominal", 16'(err0), 16'h0);

        // short frame (31 ens) raises error
        send_frame(16'hFFF8, 16'h0008, 1, 31, 1'b0, 16'h0);
        chk("err_short_frame", 16'(err0), 16'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("err_cleared", 16'(err0), 16'h0);

        // SH1/SH2 overlap, then simultaneous falls on the next en
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("err_overlap", 16'(err1), 16'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("err_cleared2", 16'(err0), 16'h0);

        // reset mid-word, then a full frame without a check on its SH2 fall
        send_frame({3'd7, 10'h3FF, 3'd0}, 16'h0, 0, 9, 1'b0, 16'h0);
        do_reset(3);
        chk("mid_reset_L", l0, 16'h0000);
        chk("mid_reset_R", r0, 16'h0000);
        send_frame({3'd7, 10'h3FF, 3'd0}, {3'd7, 10'h000, 3'd0}, 0, 31, 1'b1, 16'h7FC0);
        chk("no_err_first_sh2", 16'(err0), 16'h0);
        chk("post_reset_L", l1, 16'h7FC0);
        chk("post_reset_R", r1, 16'h8000);

        // randomized frames, stalls, occasional short frames and filler ens
        stall = 1;
        for (int f = 0; f < 30; f++) begin
            send_frame(16'($urandom), 16'($urandom),
                       ($urandom_range(0, 4) == 0) ? 1 : 0, 31, 1'b0, 16'h0);
            repeat ($urandom_range(0, 2))
                step(1'($urandom), 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
